seq_multiply: RTL and testbench

//   Iterative shift-add WIDTH x WIDTH multiplier producing a 2*WIDTH product,
//   one partial-product bit per clock. It is the arithmetic inverse companion
//   of the sequential divider and shares its start/ok handshake, so an ALU

---
 rtl/seq_multiply.sv | 108 ++++++++++
 tb/tb_seq_multiply.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/seq_multiply.sv
// seq_multiply: iterative shift-add WIDTH x WIDTH multiplier, one product bit per clock.
// Define SEQ_MUL_SIGNED_EN to add the sgn port for two's-complement operands.
module seq_multiply #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic             sgn,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] P_hi,
    output logic [WIDTH-1:0] P_lo,
    output logic             ok,
    output logic             done,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d;
    logic [WIDTH:0]   acc_q, acc_d, sum;
    logic [WIDTH-1:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;
    logic             ovf_q, ovf_d, done_q, done_d;
    logic [WIDTH-1:0] a_ld, b_ld;
    logic [2*WIDTH-1:0] prod_raw, prod;
    logic             prod_ovf;
    assign sum      = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_raw = {sum, mplier_q[WIDTH-1:1]};
`ifdef SEQ_MUL_SIGNED_EN
    logic neg_q, neg_d;
    // Multiply magnitudes and fix the sign up on the completion write.
    assign a_ld     = (sgn && A[WIDTH-1]) ? -A : A;
    assign b_ld     = (sgn && B[WIDTH-1]) ? -B : B;
    assign neg_d    = start ? (sgn & (A[WIDTH-1] ^ B[WIDTH-1])) : neg_q;
    assign prod     = neg_q ? -prod_raw : prod_raw;
    assign prod_ovf = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) neg_q <= 1'b0;
        else       neg_q <= neg_d;
    end
`else
    assign a_ld     = A;
    assign b_ld     = B;
    assign prod     = prod_raw;
    assign prod_ovf = |prod[2*WIDTH-1:WIDTH];
`endif
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        p_hi_d   = p_hi_q;
        p_lo_d   = p_lo_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        if (start) begin
            state_d  = RUN;
            cnt_d    = CW'(WIDTH - 1);
            mcand_d  = a_ld;
            mplier_d = b_ld;
            acc_d    = '0;
        end else if (state_q == RUN) begin
            acc_d    = {1'b0, sum[WIDTH:1]};
            mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                state_d = IDLE;
                p_hi_d  = prod[2*WIDTH-1:WIDTH];
                p_lo_d  = prod[WIDTH-1:0];
                ovf_d   = prod_ovf;
                done_d  = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            p_hi_q   <= '0;
            p_lo_q   <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            p_hi_q   <= p_hi_d;
            p_lo_q   <= p_lo_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end
    assign ok   = state_q == IDLE;
    assign done = done_q;
    assign P_hi = p_hi_q;
    assign P_lo = p_lo_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_seq_multiply.sv
// tb_seq_multiply: directed scoreboard bench for seq_multiply (WIDTH=32).
// Signed cases run only when SEQ_MUL_SIGNED_EN is defined.
module tb_seq_multiply;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [31:0] A = '0, B = '0, P_hi, P_lo;
    logic        ok, done, ovf;
`ifdef SEQ_MUL_SIGNED_EN
    logic        sgn = 1'b0;
`endif
    int          checks = 0, errors = 0;
    logic [64:0] sb[$];

    seq_multiply #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start),
`ifdef SEQ_MUL_SIGNED_EN
        .sgn(sgn),
`endif
        .A(A), .B(B), .P_hi(P_hi), .P_lo(P_lo), .ok(ok), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sbv;
        logic [63:0] p;
        sa  = s ? longint'($signed(a)) : longint'({32'b0, a});
        sbv = s ? longint'($signed(b)) : longint'({32'b0, b});
        p   = 64'(sa * sbv);
        return {p, s ? (p[63:32] != {32{p[31]}}) : (|p[63:32])};
    endfunction

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            chk("done_expected", 65'(sb.size() != 0), 65'd1);
            if (sb.size() != 0) chk("product", {P_hi, P_lo, ovf}, sb.pop_front());
        end
    end

    task automatic go(input logic [31:0] a, input logic [31:0] b, input logic s, input bit restart);
        A = a;
        B = b;
`ifdef SEQ_MUL_SIGNED_EN
        sgn = s;
`endif
        start = 1'b1;
        if (restart && sb.size() != 0) void'(sb.pop_back());
        sb.push_back(model(a, b, s));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run(input string tag);
        int n;
        logic busy_ok, held;
        logic [63:0] prev;
        n = 0;
        busy_ok = 1'b1;
        held = 1'b1;
        prev = {P_hi, P_lo};
        while (n < 40) begin
            @(posedge clk);
            #1 n++;
            if (done) break;
            busy_ok &= !ok;
            held &= ({P_hi, P_lo} == prev);
        end
        chk({tag, "_latency"}, 65'(n), 65'd32);
        chk({tag, "_busy"}, 65'(busy_ok), 65'd1);
        chk({tag, "_held"}, 65'(held), 65'd1);
        @(posedge clk);
        #1 chk({tag, "_after"}, 65'({done, ok}), 65'b01);
    endtask

    initial begin
        logic idle_ok;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_p", {P_hi, P_lo, ovf}, 65'd0);
        chk("reset_ctl", 65'({ok, done}), 65'b10);
        go(32'd7, 32'd6, 1'b0, 1'b0);
        run("t1");
        chk("t1_const", {P_hi, P_lo, ovf}, {32'd0, 32'd42, 1'b0});
        go(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        run("t2");
        chk("t2_const", {P_hi, P_lo, ovf}, {32'hFFFFFFFE, 32'h00000001, 1'b1});
        go(32'h12345678, 32'd0, 1'b0, 1'b0);
        run("t3");
        go(32'd9, 32'd9, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1 go(32'd3, 32'd5, 1'b0, 1'b1);
        run("t4");
        chk("t4_const", 65'(P_lo), 65'd15);
        repeat (40) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            go($urandom, $urandom, 1'b0, 1'b0);
            run("rand");
        end
        A = 32'hABCD0123;
        B = 32'h00F0F0F0;
        start = 1'b1;
        sb.push_back(model(32'hABCD0123, 32'h00F0F0F0, 1'b0));
        idle_ok = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1 idle_ok &= !ok;
        end
        start = 1'b0;
        chk("hold_busy", 65'(idle_ok), 65'd1);
        run("hold");
`ifdef SEQ_MUL_SIGNED_EN
        go(32'hFFFFFFFD, 32'd5, 1'b1, 1'b0);
        run("s1");
        chk("s1_const", {P_hi, P_lo, ovf}, {32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0});
        go(32'h80000000, 32'h80000000, 1'b1, 1'b0);
        run("s2");
        chk("s2_const", {P_hi, P_lo, ovf}, {32'h40000000, 32'h0, 1'b1});
        go(32'hFFFFFFFD, 32'd5, 1'b0, 1'b0);
        run("s3");
`endif
        go(32'h10000, 32'h10000, 1'b0, 1'b0);
        repeat (15) @(posedge clk);
        #2 reset = 1'b1;
        sb.delete();
        #1 chk("t5_p", {P_hi, P_lo, ovf}, 65'd0);
        chk("t5_ctl", 65'({ok, done}), 65'b10);
        @(posedge clk);
        #1 reset = 1'b0;
        idle_ok = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1 idle_ok &= ok & !done;
        end
        chk("t5_idle", 65'(idle_ok), 65'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
